// File: rtl/lane_traffic_if.sv
// Bundle between the game FSM / renderer / collision logic and lane_traffic.
// Master drives config, pause and queries; slave returns positions and hits.
interface lane_traffic_if #(
    parameter int NUM_LANES = 6,
    parameter int CARS      = 3,
    parameter int DIV_W     = 24
);
    logic                         enable;
    logic [1:0]                   level;
    logic                         cfg_we;
    logic [2:0]                   cfg_lane;
    logic [DIV_W-1:0]             cfg_div;
    logic [9:0]                   cfg_len;
    logic                         cfg_dir;
    logic                         q_valid;
    logic [2:0]                   q_lane;
    logic [9:0]                   q_x;
    logic [9:0]                   q_w;
    logic [NUM_LANES*CARS*10-1:0] car_x;
    logic [NUM_LANES*10-1:0]      lane_len;
    logic [NUM_LANES-1:0]         lane_dir;
    logic [NUM_LANES-1:0]         step;
    logic                         hit_valid;
    logic                         hit;

    modport master (
        output enable, level, cfg_we, cfg_lane, cfg_div, cfg_len, cfg_dir,
               q_valid, q_lane, q_x, q_w,
        input  car_x, lane_len, lane_dir, step, hit_valid, hit
    );
    modport slave (
        input  enable, level, cfg_we, cfg_lane, cfg_div, cfg_len, cfg_dir,
               q_valid, q_lane, q_x, q_w,
        output car_x, lane_len, lane_dir, step, hit_valid, hit
    );
endinterface

// File: rtl/lane_traffic.sv
// Frogger road traffic: per-lane speed divider, wrap-around car motion and a
// one-cycle registered span/car overlap query for the collision logic.
module lane_traffic_lane #(
    parameter int LANE    = 0,
    parameter int CARS    = 3,
    parameter int X_LEFT  = 96,
    parameter int X_RIGHT = 544,
    parameter int SPACING = 150,
    parameter int DIV_W   = 24,
    parameter int DEF_DIV = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable_i,
    input  logic [1:0]           level_i,
    input  logic                 cfg_we_i,
    input  logic [DIV_W-1:0]     cfg_div_i,
    input  logic [9:0]           cfg_len_i,
    input  logic                 cfg_dir_i,
    output logic [CARS-1:0][9:0] x_o,
    output logic [9:0]           len_o,
    output logic                 dir_o,
    output logic                 step_o
);
    localparam logic [9:0] RST_LEN = 10'(32 * ((LANE % 3) + 1));

    logic [DIV_W-1:0]     div_q, div_d, cnt_q, cnt_d, eff;
    logic [9:0]           len_q, len_d, len_clamp;
    logic                 dir_q, dir_d, step_q, step_d;
    logic [CARS-1:0][9:0] x_q, x_d;

    function automatic logic [9:0] seed(input int c);
        return 10'(X_LEFT + c * SPACING + (LANE % 4) * 32);
    endfunction

    always_comb begin
        eff = div_q >> level_i;
        if (eff == '0) eff = DIV_W'(1);
        len_clamp = cfg_len_i;
        if (cfg_len_i == '0)                len_clamp = 10'd1;
        else if (cfg_len_i > 10'(X_LEFT))   len_clamp = 10'(X_LEFT);

        div_d  = div_q;
        len_d  = len_q;
        dir_d  = dir_q;
        cnt_d  = cnt_q;
        x_d    = x_q;
        step_d = 1'b0;
        // A config write re-seeds the lane and takes priority over a due step.
        if (cfg_we_i) begin
            div_d = cfg_div_i;
            len_d = len_clamp;
            dir_d = cfg_dir_i;
            cnt_d = '0;
            for (int c = 0; c < CARS; c++) x_d[c] = seed(c);
        end else if (enable_i) begin
            if (cnt_q >= eff - DIV_W'(1)) begin
                cnt_d  = '0;
                step_d = 1'b1;
                for (int c = 0; c < CARS; c++) begin
                    if (!dir_q)
                        x_d[c] = (x_q[c] >= 10'(X_RIGHT)) ? 10'(X_LEFT) - len_q : x_q[c] + 10'd1;
                    else
                        x_d[c] = (({1'b0, x_q[c]} + {1'b0, len_q}) <= 11'(X_LEFT)) ?
                                 10'(X_RIGHT) : x_q[c] - 10'd1;
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= DIV_W'(DEF_DIV);
            len_q  <= RST_LEN;
            dir_q  <= 1'(LANE % 2);
            cnt_q  <= '0;
            step_q <= 1'b0;
            for (int c = 0; c < CARS; c++) x_q[c] <= seed(c);
        end else begin
            div_q  <= div_d;
            len_q  <= len_d;
            dir_q  <= dir_d;
            cnt_q  <= cnt_d;
            step_q <= step_d;
            x_q    <= x_d;
        end
    end

    assign x_o    = x_q;
    assign len_o  = len_q;
    assign dir_o  = dir_q;
    assign step_o = step_q;
endmodule

module lane_traffic #(
    parameter int NUM_LANES = 6,
    parameter int CARS      = 3,
    parameter int X_LEFT    = 96,
    parameter int X_RIGHT   = 544,
    parameter int SPACING   = 150,
    parameter int DIV_W     = 24,
    parameter int DEF_DIV   = 100000
) (
    input logic           clk,
    input logic           reset,
    lane_traffic_if.slave bus
);
    logic [NUM_LANES-1:0][CARS-1:0][9:0] x_all;
    logic [NUM_LANES-1:0][9:0]           len_all;
    logic [NUM_LANES-1:0]                dir_all, step_all;
    logic                                hit_d, hit_q, hit_valid_q;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        lane_traffic_lane #(
            .LANE(l), .CARS(CARS), .X_LEFT(X_LEFT), .X_RIGHT(X_RIGHT),
            .SPACING(SPACING), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .enable_i  (bus.enable),
            .level_i   (bus.level),
            .cfg_we_i  (bus.cfg_we && (bus.cfg_lane == 3'(l))),
            .cfg_div_i (bus.cfg_div),
            .cfg_len_i (bus.cfg_len),
            .cfg_dir_i (bus.cfg_dir),
            .x_o       (x_all[l]),
            .len_o     (len_all[l]),
            .dir_o     (dir_all[l]),
            .step_o    (step_all[l])
        );
    end

    // Out-of-range lanes never match; a zero-width span never overlaps.
    always_comb begin
        hit_d = 1'b0;
        for (int l = 0; l < NUM_LANES; l++)
            for (int c = 0; c < CARS; c++)
                if (bus.q_lane == 3'(l) &&
                    ({1'b0, x_all[l][c]} < {1'b0, bus.q_x} + {1'b0, bus.q_w}) &&
                    ({1'b0, bus.q_x} < {1'b0, x_all[l][c]} + {1'b0, len_all[l]}))
                    hit_d = 1'b1;
        if (bus.q_w == '0) hit_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_valid_q <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            hit_valid_q <= bus.q_valid;
            hit_q       <= bus.q_valid && hit_d;
        end
    end

    assign bus.car_x     = x_all;
    assign bus.lane_len  = len_all;
    assign bus.lane_dir  = dir_all;
    assign bus.step      = step_all;
    assign bus.hit_valid = hit_valid_q;
    assign bus.hit       = hit_q;
endmodule

// File: tb/tb_lane_traffic.sv
// Bench for lane_traffic: directed sequences, a query vector table and random
// traffic, all checked every cycle against a behavioural lane model.
module tb_lane_traffic;
    localparam int NL = 6, NC = 3, DW = 24;
    localparam int XL = 96, XR = 544, SP = 150, DEFD = 100000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lane_traffic_if #(.NUM_LANES(NL), .CARS(NC), .DIV_W(DW)) bus ();

    lane_traffic #(
        .NUM_LANES(NL), .CARS(NC), .X_LEFT(XL), .X_RIGHT(XR),
        .SPACING(SP), .DIV_W(DW), .DEF_DIV(DEFD)
    ) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0, errors = 0;

    // Model state: positions, per-lane config, enabled cycles since last move.
    int mx[NL][NC];
    int mlen[NL], mdir[NL], mdiv[NL], since[NL], mstep[NL];
    int mhv, mhit;

    typedef struct {
        int lane;
        int qx;
        int qw;
        int exp_hit;
    } qvec_t;
    qvec_t qt[11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int seed(input int l, input int c);
        return XL + c * SP + (l % 4) * 32;
    endfunction

    function automatic int carx(input int l, input int c);
        return int'(bus.car_x[(l*NC+c)*10 +: 10]);
    endfunction

    task automatic model_reset();
        for (int l = 0; l < NL; l++) begin
            mdiv[l] = DEFD; mlen[l] = 32 * ((l % 3) + 1); mdir[l] = l % 2;
            since[l] = 0; mstep[l] = 0;
            for (int c = 0; c < NC; c++) mx[l][c] = seed(l, c);
        end
        mhv = 0; mhit = 0;
    endtask

    task automatic model_edge();
        int ql, qx, qw, e, v;
        if (reset) begin
            model_reset();
            return;
        end
        ql = int'(bus.q_lane); qx = int'(bus.q_x); qw = int'(bus.q_w);
        mhv = int'(bus.q_valid); mhit = 0;
        if (bus.q_valid && qw != 0 && ql < NL)
            for (int c = 0; c < NC; c++)
                if (mx[ql][c] < qx + qw && qx < mx[ql][c] + mlen[ql]) mhit = 1;
        for (int l = 0; l < NL; l++) begin
            mstep[l] = 0;
            if (bus.cfg_we && int'(bus.cfg_lane) == l) begin
                v = int'(bus.cfg_len);
                if (v < 1) v = 1;
                if (v > XL) v = XL;
                mdiv[l] = int'(bus.cfg_div); mlen[l] = v; mdir[l] = int'(bus.cfg_dir);
                since[l] = 0;
                for (int c = 0; c < NC; c++) mx[l][c] = seed(l, c);
            end else if (bus.enable) begin
                e = mdiv[l] / (1 << int'(bus.level));
                if (e == 0) e = 1;
                if (since[l] + 1 >= e) begin
                    since[l] = 0; mstep[l] = 1;
                    for (int c = 0; c < NC; c++) begin
                        if (mdir[l] == 0) mx[l][c] = (mx[l][c] >= XR) ? XL - mlen[l] : mx[l][c] + 1;
                        else              mx[l][c] = (mx[l][c] + mlen[l] <= XL) ? XR : mx[l][c] - 1;
                    end
                end else begin
                    since[l]++;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int l = 0; l < NL; l++) begin
            for (int c = 0; c < NC; c++)
                chk($sformatf("car_x[%0d][%0d]", l, c), carx(l, c), mx[l][c]);
            chk($sformatf("lane_len[%0d]", l), int'(bus.lane_len[l*10 +: 10]), mlen[l]);
            chk($sformatf("lane_dir[%0d]", l), int'(bus.lane_dir[l]), mdir[l]);
            chk($sformatf("step[%0d]", l), int'(bus.step[l]), mstep[l]);
        end
        chk("hit_valid", int'(bus.hit_valid), mhv);
        chk("hit", int'(bus.hit), mhit);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic cfg_write(input int lane, input int div, input int len, input int dir);
        bus.cfg_we = 1'b1; bus.cfg_lane = 3'(lane); bus.cfg_div = DW'(div);
        bus.cfg_len = 10'(len); bus.cfg_dir = 1'(dir);
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int found, nsteps;
        qt[0]  = '{0, 131, 1, 1};   qt[1]  = '{0, 132, 1, 0};
        qt[2]  = '{0, 90, 10, 0};   qt[3]  = '{0, 90, 11, 1};
        qt[4]  = '{6, 100, 20, 0};  qt[5]  = '{0, 110, 0, 0};
        qt[6]  = '{0, 280, 5, 1};   qt[7]  = '{0, 282, 5, 0};
        qt[8]  = '{1, 100, 28, 0};  qt[9]  = '{1, 100, 29, 1};
        qt[10] = '{7, 100, 20, 0};

        model_reset();
        reset = 1'b1;
        bus.enable = 1'b0; bus.level = 2'd0; bus.cfg_we = 1'b0; bus.cfg_lane = '0;
        bus.cfg_div = '0; bus.cfg_len = '0; bus.cfg_dir = 1'b0;
        bus.q_valid = 1'b0; bus.q_lane = '0; bus.q_x = '0; bus.q_w = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_lane_dir", int'(bus.lane_dir), 6'b101010);
        chk("rst_car00", carx(0, 0), 96);
        chk("rst_car32", carx(3, 2), 492);
        chk("rst_hit_valid", int'(bus.hit_valid), 0);

        // Basic stepping: div=4 moves on every 4th enabled edge.
        cfg_write(0, 4, 32, 0);
        bus.enable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 3) chk("basic_no_step3", int'(bus.step[0]), 0);
            if (i == 4) begin
                chk("basic_car_4", carx(0, 0), 97);
                chk("basic_step_4", int'(bus.step[0]), 1);
            end
            if (i == 8) chk("basic_car_8", carx(0, 0), 98);
        end
        bus.enable = 1'b0;
        repeat (10) tick();
        chk("pause_hold", carx(0, 0), 98);

        // Query vector table, issued back to back.
        do_reset();
        cfg_write(0, 1, 32, 0);
        bus.enable = 1'b1;
        repeat (4) tick();
        bus.enable = 1'b0;
        chk("q_setup_car0", carx(0, 0), 100);
        for (int i = 0; i < 11; i++) begin
            bus.q_valid = 1'b1; bus.q_lane = 3'(qt[i].lane);
            bus.q_x = 10'(qt[i].qx); bus.q_w = 10'(qt[i].qw);
            tick();
            chk($sformatf("qvec%0d_valid", i), int'(bus.hit_valid), 1);
            chk($sformatf("qvec%0d_hit", i), int'(bus.hit), qt[i].exp_hit);
        end
        bus.q_valid = 1'b0;
        tick();
        chk("q_idle_valid", int'(bus.hit_valid), 0);
        chk("q_idle_hit", int'(bus.hit), 0);

        // Left-to-right wrap at X_RIGHT.
        cfg_write(0, 1, 32, 0);
        bus.enable = 1'b1;
        found = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            tick();
            if (carx(0, 0) == 544) found = 1;
        end
        chk("ltr_reach_544", found, 1);
        tick();
        chk("ltr_wrap", carx(0, 0), 64);
        tick();
        chk("ltr_after_wrap", carx(0, 0), 65);

        // Right-to-left with level=2 (eff=2); wraps once x+len <= X_LEFT.
        cfg_write(1, 8, 64, 1);
        bus.level = 2'd2;
        nsteps = 0;
        for (int i = 0; i < 300 && nsteps < 96; i++) begin
            tick();
            if (bus.step[1]) begin
                nsteps++;
                if (nsteps == 32) chk("rtl_32steps", carx(1, 0), 96);
                if (nsteps == 64) chk("rtl_64steps", carx(1, 0), 64);
            end
        end
        chk("rtl_nsteps", nsteps, 96);
        chk("rtl_96steps", carx(1, 0), 32);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            tick();
            if (bus.step[1]) found = 1;
        end
        chk("rtl_step_seen", found, 1);
        chk("rtl_wrap", carx(1, 0), 544);

        // Config write on the edge where lane 2 is due: config wins.
        bus.level = 2'd0;
        cfg_write(2, 3, 32, 0);
        tick(); tick();
        cfg_write(2, 3, 200, 0);
        chk("coll_no_step", int'(bus.step[2]), 0);
        chk("coll_car0", carx(2, 0), 160);
        chk("coll_car1", carx(2, 1), 310);
        chk("coll_car2", carx(2, 2), 460);
        chk("coll_len_clamp", int'(bus.lane_len[20 +: 10]), 96);
        tick(); tick();
        chk("coll_restart_wait", int'(bus.step[2]), 0);
        tick();
        chk("coll_restart_step", int'(bus.step[2]), 1);
        cfg_write(7, 5, 10, 1);
        chk("bad_lane_len2", int'(bus.lane_len[20 +: 10]), 96);
        chk("bad_lane_dir", int'(bus.lane_dir), 6'b101010);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bus.enable   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) bus.level = 2'($urandom_range(0, 3));
            bus.cfg_we   = ($urandom_range(0, 19) == 0);
            bus.cfg_lane = 3'($urandom_range(0, 7));
            bus.cfg_div  = DW'($urandom_range(0, 12));
            bus.cfg_len  = 10'($urandom_range(0, 1023));
            bus.cfg_dir  = 1'($urandom_range(0, 1));
            bus.q_valid  = 1'($urandom_range(0, 1));
            bus.q_lane   = 3'($urandom_range(0, 7));
            bus.q_x      = 10'($urandom_range(0, 600));
            bus.q_w      = 10'($urandom_range(0, 120));
            tick();
        end
        bus.cfg_we = 1'b0;

        // Reset with a query in flight.
        bus.q_valid = 1'b1; bus.q_lane = 3'd0; bus.q_x = 10'd0; bus.q_w = 10'd1000;
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_hit_valid", int'(bus.hit_valid), 0);
        chk("midrst_hit", int'(bus.hit), 0);
        chk("midrst_lane_dir", int'(bus.lane_dir), 6'b101010);
        chk("midrst_car00", carx(0, 0), 96);
        chk("midrst_car32", carx(3, 2), 492);
        reset = 1'b0;
        bus.q_valid = 1'b0;
        bus.level = 2'd0;
        bus.enable = 1'b1;
        repeat (20) tick();
        chk("midrst_no_move", carx(1, 0), 128);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
